// File: rtl/core_pkg.sv
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared types and default latencies for the hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [2:0] {LC_ALU, LC_LOAD, LC_MUL, LC_DIV, LC_FPU} lat_class_e;
  typedef enum logic [1:0] {NO_WB, WB_ALU, WB_MEM, WB_PC} wb_sel_e;
  typedef enum logic [1:0] {IT_OTHER, BRANCH, JUMP_R, IT_JUMP} inst_type_e;
  typedef enum logic {SIG_LOW = 1'b0, SIG_HIGH = 1'b1} onebit_sig_e;

  // Bit 5 set marks an unused operand slot; bits 4:0 are the register index.
  typedef logic [5:0] reg_id_t;
  localparam reg_id_t NO_REG = 6'h20;

  typedef struct packed {
    inst_type_e inst_type;
    wb_sel_e    wb_sel;
    reg_id_t    rs1_int;
    reg_id_t    rs2_int;
    reg_id_t    rd_int;
    reg_id_t    rs1_float;
    reg_id_t    rs2_float;
    reg_id_t    rs3_float;
    reg_id_t    rd_float;
  } ctrl_bus_e;

  localparam int C_DEF_ALU_LAT  = 0;
  localparam int C_DEF_LOAD_LAT = 1;
  localparam int C_DEF_MUL_LAT  = 2;
  localparam int C_DEF_BR_EXTRA = 1;
  localparam int C_DEF_FPU_LAT  = 3;

  function automatic int max_lat(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int C_DEF_CNT_W = $clog2(max_lat(C_DEF_ALU_LAT, C_DEF_LOAD_LAT, C_DEF_MUL_LAT,
                                              C_DEF_FPU_LAT) + C_DEF_BR_EXTRA + 2);
  localparam logic [C_DEF_CNT_W-1:0] DIV_PEND = '1;

endpackage

`default_nettype wire

// File: rtl/sb_reg_counter.sv
// ============================================================================
// Module   : sb_reg_counter
// Purpose  : One register's latency counter with arm/done/decrement priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_reg_counter #(
  parameter int CNT_W    = 3,
  parameter int BR_EXTRA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_arm,
  input  logic [CNT_W-1:0] i_arm_val,
  input  logic             i_div_done,
  input  logic [CNT_W-1:0] i_waw_lim,
  output logic             o_busy,
  output logic             o_pend,
  output logic             o_norm_stall,
  output logic             o_br_stall,
  output logic             o_waw_stall
);

  localparam logic [CNT_W-1:0] C_PEND = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_arm) begin
      r_cnt <= i_arm_val;
    end else if (r_cnt == C_PEND) begin
      if (i_div_done) r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy       = (r_cnt != '0);
  assign o_pend       = (r_cnt == C_PEND);
  assign o_norm_stall = (r_cnt > CNT_W'(BR_EXTRA));
  assign o_br_stall   = o_busy;
  // A new writer is safe once the old count, decremented this cycle, fits under its arm value.
  assign o_waw_stall  = o_pend ||
                        ({1'b0, r_cnt} > ({1'b0, i_waw_lim} + (CNT_W+1)'(1)));

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register latency scoreboard driving the IF/ID bubble request.
//            Optional float bank enabled by macro SCOREBOARD_FPU_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_INT_REGS = 32,
  parameter int ALU_LAT      = C_DEF_ALU_LAT,
  parameter int LOAD_LAT     = C_DEF_LOAD_LAT,
  parameter int MUL_LAT      = C_DEF_MUL_LAT,
  parameter int BR_EXTRA     = C_DEF_BR_EXTRA,
  parameter int FPU_LAT      = C_DEF_FPU_LAT,
  parameter int CNT_W        = $clog2(max_lat(ALU_LAT, LOAD_LAT, MUL_LAT, FPU_LAT) + BR_EXTRA + 2)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  ctrl_bus_e               ctrl_bus_if_id_i,
  input  lat_class_e              op_class_i,
  input  logic                    issue_i,
  input  logic                    flush_i,
  input  logic                    div_done_i,
  input  logic [4:0]              div_rd_i,
  output onebit_sig_e             insert_bubble_o,
  output logic [NUM_INT_REGS-1:0] int_busy_o,
  output logic                    div_pending_o
`ifdef SCOREBOARD_FPU_EN
  ,
  output logic [31:0]             fp_busy_o
`endif
);

  localparam logic [CNT_W-1:0] C_DIV_PEND = '1;

  logic             w_is_br, w_int_prod, w_src_stall, w_waw_stall, w_bubble, w_adv;
  logic [4:0]       w_rd_idx;
  logic [CNT_W-1:0] w_int_arm_val;
  logic [31:0]      w_busy, w_pend, w_nstall, w_bstall, w_waw;

  function automatic logic src_hit(input reg_id_t id, input logic [31:0] ns,
                                   input logic [31:0] bs, input logic is_br,
                                   input logic skip_x0);
    if (id[5] || (skip_x0 && id[4:0] == 5'd0)) return 1'b0;
    return is_br ? bs[id[4:0]] : ns[id[4:0]];
  endfunction

  assign w_is_br    = (ctrl_bus_if_id_i.inst_type == BRANCH) ||
                      (ctrl_bus_if_id_i.inst_type == JUMP_R);
  assign w_rd_idx   = ctrl_bus_if_id_i.rd_int[4:0];
  assign w_int_prod = (ctrl_bus_if_id_i.wb_sel != NO_WB) && !ctrl_bus_if_id_i.rd_int[5] &&
                      (w_rd_idx != 5'd0);

  always_comb begin
    w_int_arm_val = CNT_W'(ALU_LAT + BR_EXTRA);
    case (op_class_i)
      LC_LOAD: w_int_arm_val = CNT_W'(LOAD_LAT + BR_EXTRA);
      LC_MUL:  w_int_arm_val = CNT_W'(MUL_LAT + BR_EXTRA);
      LC_DIV:  w_int_arm_val = C_DIV_PEND;
`ifdef SCOREBOARD_FPU_EN
      LC_FPU:  w_int_arm_val = CNT_W'(FPU_LAT + BR_EXTRA);
`endif
      default: ;
    endcase
  end

  for (genvar r = 0; r < 32; r++) begin : g_int
    if (r != 0 && r < NUM_INT_REGS) begin : g_cnt
      sb_reg_counter #(.CNT_W(CNT_W), .BR_EXTRA(BR_EXTRA)) u_cnt (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_arm        (w_adv && w_int_prod && (w_rd_idx == 5'(r))),
        .i_arm_val    (w_int_arm_val),
        .i_div_done   (div_done_i && (div_rd_i == 5'(r))),
        .i_waw_lim    (w_int_arm_val),
        .o_busy       (w_busy[r]),
        .o_pend       (w_pend[r]),
        .o_norm_stall (w_nstall[r]),
        .o_br_stall   (w_bstall[r]),
        .o_waw_stall  (w_waw[r])
      );
    end else begin : g_none
      assign w_busy[r]   = 1'b0;
      assign w_pend[r]   = 1'b0;
      assign w_nstall[r] = 1'b0;
      assign w_bstall[r] = 1'b0;
      assign w_waw[r]    = 1'b0;
    end
  end

`ifdef SCOREBOARD_FPU_EN
  localparam logic [CNT_W-1:0] C_FPU_ARM = CNT_W'(FPU_LAT + BR_EXTRA);

  logic        w_fp_prod;
  logic [31:0] w_fbusy, w_fnstall, w_fbstall, w_fwaw, w_unused_fpend;

  assign w_fp_prod = (op_class_i == LC_FPU) && (ctrl_bus_if_id_i.wb_sel != NO_WB) &&
                     !ctrl_bus_if_id_i.rd_float[5];

  for (genvar f = 0; f < 32; f++) begin : g_fp
    sb_reg_counter #(.CNT_W(CNT_W), .BR_EXTRA(BR_EXTRA)) u_fcnt (
      .clk          (clk_i),
      .rst          (rst_i),
      .i_arm        (w_adv && w_fp_prod && (ctrl_bus_if_id_i.rd_float[4:0] == 5'(f))),
      .i_arm_val    (C_FPU_ARM),
      .i_div_done   (1'b0),
      .i_waw_lim    (C_FPU_ARM),
      .o_busy       (w_fbusy[f]),
      .o_pend       (w_unused_fpend[f]),
      .o_norm_stall (w_fnstall[f]),
      .o_br_stall   (w_fbstall[f]),
      .o_waw_stall  (w_fwaw[f])
    );
  end

  assign fp_busy_o = rst_i ? '0 : w_fbusy;
`else
  logic w_unused_fp;
  assign w_unused_fp = ^{ctrl_bus_if_id_i.rs1_float, ctrl_bus_if_id_i.rs2_float,
                         ctrl_bus_if_id_i.rs3_float, ctrl_bus_if_id_i.rd_float};
`endif

  always_comb begin
    w_src_stall = src_hit(ctrl_bus_if_id_i.rs1_int, w_nstall, w_bstall, w_is_br, 1'b1) |
                  src_hit(ctrl_bus_if_id_i.rs2_int, w_nstall, w_bstall, w_is_br, 1'b1);
    w_waw_stall = w_int_prod & w_waw[w_rd_idx];
`ifdef SCOREBOARD_FPU_EN
    w_src_stall = w_src_stall |
                  src_hit(ctrl_bus_if_id_i.rs1_float, w_fnstall, w_fbstall, w_is_br, 1'b0) |
                  src_hit(ctrl_bus_if_id_i.rs2_float, w_fnstall, w_fbstall, w_is_br, 1'b0) |
                  src_hit(ctrl_bus_if_id_i.rs3_float, w_fnstall, w_fbstall, w_is_br, 1'b0);
    w_waw_stall = w_waw_stall | (w_fp_prod & w_fwaw[ctrl_bus_if_id_i.rd_float[4:0]]);
`endif
  end

  assign w_bubble        = (w_src_stall | w_waw_stall) & issue_i & !flush_i & !rst_i;
  assign w_adv           = issue_i & !flush_i & !w_bubble & !rst_i;
  assign insert_bubble_o = onebit_sig_e'(w_bubble);
  assign int_busy_o      = rst_i ? '0 : w_busy[NUM_INT_REGS-1:0];
  assign div_pending_o   = !rst_i && (|w_pend);

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed plus randomized checks against a ready-time model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;
  import core_pkg::*;

  localparam int BR = 1;

  logic        clk = 1'b0;
  logic        rst;
  ctrl_bus_e   ctrl;
  lat_class_e  cls;
  logic        issue, flush, done;
  logic [4:0]  drd;
  onebit_sig_e bub;
  logic [31:0] busy;
  logic        dpend;
`ifdef SCOREBOARD_FPU_EN
  logic [31:0] fbusy;
`endif

  hazard_scoreboard dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ctrl_bus_if_id_i (ctrl),
    .op_class_i       (cls),
    .issue_i          (issue),
    .flush_i          (flush),
    .div_done_i       (done),
    .div_rd_i         (drd),
    .insert_bubble_o  (bub),
    .int_busy_o       (busy),
    .div_pending_o    (dpend)
`ifdef SCOREBOARD_FPU_EN
    ,
    .fp_busy_o        (fbusy)
`endif
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  // Model: cycle index at which a normal / branch consumer may first issue.
  longint now = 0;
  longint rn[32], rb[32], frn[32], frb[32];
  bit     pd[32];
  logic   last_bub;

  function automatic int lat_of(input lat_class_e k);
    case (k)
      LC_LOAD: return 1;
      LC_MUL:  return 2;
`ifdef SCOREBOARD_FPU_EN
      LC_FPU:  return 3;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic bit ivalid(input reg_id_t id);
    return !id[5] && id[4:0] != 5'd0;
  endfunction

  function automatic bit stall_i(input reg_id_t id, input bit br);
    if (!ivalid(id)) return 0;
    if (pd[id[4:0]]) return 1;
    return br ? (now < rb[id[4:0]]) : (now < rn[id[4:0]]);
  endfunction

  function automatic bit stall_f(input reg_id_t id, input bit br);
    if (id[5]) return 0;
    return br ? (now < frb[id[4:0]]) : (now < frn[id[4:0]]);
  endfunction

  function automatic ctrl_bus_e mk(input inst_type_e it, input wb_sel_e wb, input reg_id_t rd,
                                   input reg_id_t s1, input reg_id_t s2);
    ctrl_bus_e c;
    c.inst_type = it;   c.wb_sel = wb;
    c.rd_int    = rd;   c.rs1_int = s1;  c.rs2_int = s2;
    c.rs1_float = NO_REG; c.rs2_float = NO_REG; c.rs3_float = NO_REG; c.rd_float = NO_REG;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input ctrl_bus_e c, input lat_class_e k, input logic is,
                      input logic fl, input logic dn, input logic [4:0] dr);
    bit          br, ip, fp;
    logic        eb;
    logic [31:0] ebusy;
    int          l;
    rst = r; ctrl = c; cls = k; issue = is; flush = fl; done = dn; drd = dr;
    #2;
    br = (c.inst_type == BRANCH) || (c.inst_type == JUMP_R);
    ip = (c.wb_sel != NO_WB) && ivalid(c.rd_int);
    fp = 0;
`ifdef SCOREBOARD_FPU_EN
    fp = (k == LC_FPU) && (c.wb_sel != NO_WB) && !c.rd_float[5];
`endif
    l  = lat_of(k);
    eb = 0;
    if (!r) begin
      eb = stall_i(c.rs1_int, br) | stall_i(c.rs2_int, br);
      if (ip) eb = eb | pd[c.rd_int[4:0]] |
                   ((k != LC_DIV) && (now < rb[c.rd_int[4:0]] - 1 - (l + BR)));
`ifdef SCOREBOARD_FPU_EN
      eb = eb | stall_f(c.rs1_float, br) | stall_f(c.rs2_float, br) | stall_f(c.rs3_float, br);
      if (fp) eb = eb | (now < frb[c.rd_float[4:0]] - 1 - (3 + BR));
`endif
      eb = eb & is & !fl;
    end
    ebusy = '0;
    for (int i = 0; i < 32; i++) ebusy[i] = !r && (pd[i] || now < rb[i]);
    chk("bubble", 32'(bub), 32'(eb));
    chk("int_busy", busy, ebusy);
    chk("div_pending", 32'(dpend), 32'(!r && (ebusy & {32{1'b1}}) != 0 &&
                                       (pd.sum() with (int'(item)) != 0)));
`ifdef SCOREBOARD_FPU_EN
    ebusy = '0;
    for (int i = 0; i < 32; i++) ebusy[i] = !r && (now < frb[i]);
    chk("fp_busy", fbusy, ebusy);
`endif
    last_bub = bub;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        pd[i] = 0; rn[i] = 0; rb[i] = 0; frn[i] = 0; frb[i] = 0;
      end
    end else begin
      if (dn && pd[dr]) begin pd[dr] = 0; rn[dr] = 0; rb[dr] = 0; end
      if (is && !fl && !eb) begin
        if (ip) begin
          if (k == LC_DIV) pd[c.rd_int[4:0]] = 1;
          else begin
            pd[c.rd_int[4:0]] = 0;
            rn[c.rd_int[4:0]] = now + 1 + l;
            rb[c.rd_int[4:0]] = now + 1 + l + BR;
          end
        end
        if (fp) begin
          frn[c.rd_float[4:0]] = now + 1 + 3;
          frb[c.rd_float[4:0]] = now + 1 + 3 + BR;
        end
      end
    end
    now++;
    #1;
  endtask

  function automatic reg_id_t rnd_reg();
    int v;
    v = $urandom_range(0, 7);
    return (v == 7) ? NO_REG : reg_id_t'(v);
  endfunction

  ctrl_bus_e nop, c2;
  int        nb;

  initial begin
    for (int i = 0; i < 32; i++) begin
      pd[i] = 0; rn[i] = 0; rb[i] = 0; frn[i] = 0; frb[i] = 0;
    end
    nop = mk(IT_OTHER, NO_WB, NO_REG, NO_REG, NO_REG);
    rst = 1; ctrl = nop; cls = LC_ALU; issue = 0; flush = 0; done = 0; drd = 0;
    @(posedge clk); #1;
    step(1, nop, LC_ALU, 0, 0, 0, 0);
    step(1, mk(IT_OTHER, WB_ALU, 6'd5, 6'd1, 6'd2), LC_ALU, 1, 0, 0, 0);
    chk("reset_bubble", 32'(last_bub), 0);

    // ALU -> ALU, ALU -> branch
    step(0, mk(IT_OTHER, WB_ALU, 6'd5, 6'd1, 6'd2), LC_ALU, 1, 0, 0, 0);
    step(0, mk(IT_OTHER, WB_ALU, 6'd6, 6'd5, NO_REG), LC_ALU, 1, 0, 0, 0);
    chk("alu_alu", 32'(last_bub), 0);
    repeat (4) step(0, nop, LC_ALU, 0, 0, 0, 0);
    step(0, mk(IT_OTHER, WB_ALU, 6'd5, 6'd1, 6'd2), LC_ALU, 1, 0, 0, 0);
    step(0, mk(BRANCH, NO_WB, NO_REG, 6'd5, NO_REG), LC_ALU, 1, 0, 0, 0);
    chk("alu_br_1", 32'(last_bub), 1);
    step(0, mk(BRANCH, NO_WB, NO_REG, 6'd5, NO_REG), LC_ALU, 1, 0, 0, 0);
    chk("alu_br_2", 32'(last_bub), 0);

    // load -> branch, load -> add
    step(0, mk(IT_OTHER, WB_MEM, 6'd7, 6'd1, NO_REG), LC_LOAD, 1, 0, 0, 0);
    step(0, mk(BRANCH, NO_WB, NO_REG, 6'd7, 6'd0), LC_ALU, 1, 0, 0, 0);
    chk("ld_br_1", 32'(last_bub), 1);
    step(0, mk(BRANCH, NO_WB, NO_REG, 6'd7, 6'd0), LC_ALU, 1, 0, 0, 0);
    chk("ld_br_2", 32'(last_bub), 1);
    step(0, mk(BRANCH, NO_WB, NO_REG, 6'd7, 6'd0), LC_ALU, 1, 0, 0, 0);
    chk("ld_br_3", 32'(last_bub), 0);
    repeat (3) step(0, nop, LC_ALU, 0, 0, 0, 0);
    step(0, mk(IT_OTHER, WB_MEM, 6'd7, 6'd1, NO_REG), LC_LOAD, 1, 0, 0, 0);
    step(0, mk(IT_OTHER, WB_ALU, 6'd8, 6'd7, NO_REG), LC_ALU, 1, 0, 0, 0);
    chk("ld_add_1", 32'(last_bub), 1);
    step(0, mk(IT_OTHER, WB_ALU, 6'd8, 6'd7, NO_REG), LC_ALU, 1, 0, 0, 0);
    chk("ld_add_2", 32'(last_bub), 0);

    // divide held for 20 cycles, then released
    step(0, mk(IT_OTHER, WB_ALU, 6'd9, 6'd1, NO_REG), LC_DIV, 1, 0, 0, 0);
    nb = 0;
    repeat (20) begin
      step(0, mk(IT_OTHER, WB_ALU, 6'd10, 6'd9, NO_REG), LC_ALU, 1, 0, 0, 0);
      nb += int'(last_bub);
    end
    chk("div_hold", 32'(nb), 20);
    chk("div_pend", 32'(dpend), 1);
    step(0, mk(IT_OTHER, WB_ALU, 6'd10, 6'd9, NO_REG), LC_ALU, 1, 0, 1, 5'd9);
    chk("div_done_cycle", 32'(last_bub), 1);
    step(0, mk(IT_OTHER, WB_ALU, 6'd10, 6'd9, NO_REG), LC_ALU, 1, 0, 0, 0);
    chk("div_release", 32'(last_bub), 0);

    // MUL then WAW by ALU
    repeat (3) step(0, nop, LC_ALU, 0, 0, 0, 0);
    step(0, mk(IT_OTHER, WB_ALU, 6'd3, 6'd1, NO_REG), LC_MUL, 1, 0, 0, 0);
    step(0, mk(IT_OTHER, WB_ALU, 6'd3, 6'd2, NO_REG), LC_ALU, 1, 0, 0, 0);
    chk("waw_1", 32'(last_bub), 1);
    step(0, mk(IT_OTHER, WB_ALU, 6'd3, 6'd2, NO_REG), LC_ALU, 1, 0, 0, 0);
    chk("waw_2", 32'(last_bub), 0);

    // flushed producer never arms
    repeat (4) step(0, nop, LC_ALU, 0, 0, 0, 0);
    step(0, mk(IT_OTHER, WB_MEM, 6'd4, 6'd1, NO_REG), LC_LOAD, 1, 1, 0, 0);
    step(0, nop, LC_ALU, 0, 0, 0, 0);
    chk("flush_busy", busy, 0);

    // reset with divide outstanding
    step(0, mk(IT_OTHER, WB_ALU, 6'd9, 6'd1, NO_REG), LC_DIV, 1, 0, 0, 0);
    chk("div_armed", 32'(dpend), 1);
    step(1, nop, LC_ALU, 0, 0, 0, 0);
    step(0, nop, LC_ALU, 0, 0, 0, 0);
    chk("rst_div_pend", 32'(dpend), 0);
    chk("rst_busy", busy, 0);

    // FPU -> FMA on rs3
    c2 = nop; c2.wb_sel = WB_ALU; c2.rd_float = 6'd2;
    step(0, c2, LC_FPU, 1, 0, 0, 0);
    c2 = nop; c2.wb_sel = WB_ALU; c2.rd_float = 6'd3; c2.rs3_float = 6'd2;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, c2, LC_FPU, 1, 0, 0, 0);
      if (!last_bub) break;
      nb++;
    end
`ifdef SCOREBOARD_FPU_EN
    chk("fpu_fma_bubbles", 32'(nb), 3);
`else
    chk("fpu_fma_bubbles", 32'(nb), 0);
`endif

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      ctrl_bus_e  rc;
      lat_class_e rk;
      int         v;
      rc = mk(inst_type_e'($urandom_range(0, 3)), wb_sel_e'($urandom_range(0, 3)),
              rnd_reg(), rnd_reg(), rnd_reg());
      rc.rs1_float = ($urandom_range(0, 4) == 4) ? NO_REG : reg_id_t'($urandom_range(0, 3));
      rc.rs2_float = ($urandom_range(0, 4) == 4) ? NO_REG : reg_id_t'($urandom_range(0, 3));
      rc.rs3_float = ($urandom_range(0, 1) == 1) ? NO_REG : reg_id_t'($urandom_range(0, 3));
      rc.rd_float  = ($urandom_range(0, 3) == 3) ? NO_REG : reg_id_t'($urandom_range(0, 3));
      v  = $urandom_range(0, 15);
      rk = (v == 0) ? LC_DIV : lat_class_e'(v % 4 == 3 ? 4 : v % 4);
      step(($urandom_range(0, 63) == 0), rc, rk, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
           5'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
